// File: rtl/vector_ram_if.sv
// vector_ram_if
// Request/response bundle between an SpMV kernel (master) and the dense
// vector storage (slave). A request beat carries PARALLELISM independent lane
// addresses plus write data. A read beat returns one PARALLELISM-wide
// response through valid/ready.
//   valid/ready/write : request beat handshake and direction (1 = write)
//   addr[]/wdata[]    : per-lane entry index and write data
//   rdata[]/rvalid    : per-lane read data of the oldest pending response
//   rready            : master consumes the response beat
`timescale 1ns/1ps
interface vector_ram_if #(
  parameter int LENGTH      = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4,
  parameter int ADDR_WIDTH  = $clog2(LENGTH)
);
  logic                  valid;
  logic                  ready;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr  [PARALLELISM];
  logic [DATA_WIDTH-1:0] wdata [PARALLELISM];
  logic [DATA_WIDTH-1:0] rdata [PARALLELISM];
  logic                  rvalid;
  logic                  rready;

  modport master (
    output valid, write, addr, wdata, rready,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  valid, write, addr, wdata, rready,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/vector_ram_responder.sv
// vector_ram_responder
// Memory-side responder for vector_ram_if. Holds LENGTH x DATA_WIDTH vector
// entries in a flop array with PARALLELISM combinational read ports and
// PARALLELISM write ports. Read beats are answered in order through a
// 2-entry response FIFO; write beats commit at the accept edge and produce no
// response.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset (memory contents are not reset)
//   vec   : vector_ram_if slave modport (valid/ready/write/addr/wdata in,
//           rdata/rvalid out, rready in)
`timescale 1ns/1ps
module vector_ram_responder (
  input  logic        clk,
  input  logic        rst_n,
  vector_ram_if.slave vec
);

  localparam int LENGTH = vec.LENGTH;
  localparam int DW     = vec.DATA_WIDTH;
  localparam int P      = vec.PARALLELISM;
  localparam logic [31:0] LENGTH_U = 32'(LENGTH);

  // FIFO occupancy doubles as the state encoding (value == entry count).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  fifo_state_e state_reg;
  fifo_state_e state_next;

  // Held low through reset and for the edge on which reset is released, so a
  // beat presented on the deassert edge is never accepted.
  logic ready_en_reg;

  logic [DW-1:0] mem      [LENGTH];
  logic [DW-1:0] head_reg [P];
  logic [DW-1:0] tail_reg [P];
  logic [DW-1:0] rd_lane  [P];
  logic [P-1:0]  lane_ok;

  logic ready_int;
  logic rvalid_int;
  logic accept;
  logic push;
  logic pop;
  logic wr_fire;

  // FIFO data-path steering produced by the state machine.
  logic head_from_rd;
  logic head_from_tail;
  logic tail_from_rd;

  // ready/rvalid come only from registered state, never from rready or write.
  assign ready_int  = ready_en_reg && (state_reg != FULL);
  assign rvalid_int = (state_reg != EMPTY);

  assign accept  = vec.valid && ready_int;
  assign push    = accept && !vec.write;
  assign wr_fire = accept && vec.write;
  assign pop     = rvalid_int && vec.rready;

  assign vec.ready  = ready_int;
  assign vec.rvalid = rvalid_int;

  // Per-lane read ports and range qualification. Lanes whose address falls
  // beyond LENGTH (only possible when LENGTH is not a power of two) read as
  // zero and have their writes dropped.
  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      assign lane_ok[gi]   = (32'(vec.addr[gi]) < LENGTH_U);
      assign rd_lane[gi]   = lane_ok[gi] ? mem[vec.addr[gi]] : '0;
      assign vec.rdata[gi] = head_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          head_reg[gi] <= '0;
          tail_reg[gi] <= '0;
        end else begin
          if (head_from_rd) begin
            head_reg[gi] <= rd_lane[gi];
          end else if (head_from_tail) begin
            head_reg[gi] <= tail_reg[gi];
          end
          if (tail_from_rd) begin
            tail_reg[gi] <= rd_lane[gi];
          end
        end
      end
    end
  endgenerate

  // Storage write. Lanes are visited in increasing index order so that when
  // several lanes target the same entry the highest lane's data lands.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < P; i++) begin
        if (lane_ok[i]) begin
          mem[vec.addr[i]] <= vec.wdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
    end
  end

  // Next state and FIFO steering. The head entry always drives rdata; the
  // tail only fills when a push arrives while the head is still waiting.
  always_comb begin
    state_next     = state_reg;
    head_from_rd   = 1'b0;
    head_from_tail = 1'b0;
    tail_from_rd   = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          state_next   = ONE;
          head_from_rd = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_from_rd = 1'b1;
        end else if (push) begin
          state_next   = FULL;
          tail_from_rd = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // ready is low here, so only a pop can happen.
        if (pop) begin
          state_next     = ONE;
          head_from_tail = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_ram_responder.sv
`timescale 1ns/1ps
module tb_vector_ram_responder;

  localparam int LEN = 12;
  localparam int DW  = 32;
  localparam int P   = 4;
  localparam int AW  = $clog2(LEN);
  localparam int VW  = P * DW;
  localparam int AVW = P * AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_ram_if #(.LENGTH(LEN), .DATA_WIDTH(DW), .PARALLELISM(P)) vif ();

  vector_ram_responder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vec  (vif)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int rsp_count = 0;
  bit lat_check = 1'b0;

  logic [VW-1:0] exp_q[$];
  int            acc_cyc_q[$];
  logic [DW-1:0] model [LEN];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [VW-1:0] rdata_pk();
    logic [VW-1:0] r;
    for (int i = 0; i < P; i++) r[i*DW +: DW] = vif.rdata[i];
    return r;
  endfunction

  // Lane 0 is the first argument.
  function automatic logic [VW-1:0] pk(logic [DW-1:0] d0, logic [DW-1:0] d1,
                                       logic [DW-1:0] d2, logic [DW-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [AVW-1:0] pa(int a0, int a1, int a2, int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [VW-1:0] model_read(logic [AVW-1:0] a);
    logic [VW-1:0] r;
    int ai;
    for (int i = 0; i < P; i++) begin
      ai = int'(a[i*AW +: AW]);
      r[i*DW +: DW] = (ai < LEN) ? model[ai] : '0;
    end
    return r;
  endfunction

  // Present one beat and hold it until accepted. Reads push their expected
  // response (hand value or model) once the accept edge has passed.
  task automatic send(input bit wr, input logic [AVW-1:0] a, input logic [VW-1:0] d,
                      input logic [VW-1:0] exp, input bit use_model);
    bit done = 1'b0;
    int waitc = 0;
    int ai;
    vif.valid = 1'b1;
    vif.write = wr;
    for (int i = 0; i < P; i++) begin
      vif.addr[i]  = a[i*AW +: AW];
      vif.wdata[i] = d[i*DW +: DW];
    end
    while (!done) begin
      @(negedge clk);
      if (vif.ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        if (wr) begin
          for (int i = 0; i < P; i++) begin
            ai = int'(a[i*AW +: AW]);
            if (ai < LEN) model[ai] = d[i*DW +: DW];
          end
        end else begin
          exp_q.push_back(use_model ? model_read(a) : exp);
          acc_cyc_q.push_back(cyc);
        end
      end else begin
        waitc++;
        if (waitc > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: got ready=0 for %0d cycles expected acceptance", waitc);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    vif.valid = 1'b0;
    vif.write = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on every consumed response and
  // checks that a stalled response holds still.
  logic [VW-1:0] held;
  bit            held_v = 1'b0;
  logic [VW-1:0] mon_exp;
  int            mon_acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("rvalid_held", VW'(vif.rvalid), VW'(1));
        chk("rdata_stable", rdata_pk(), held);
      end
      held_v = 1'b0;
      if (vif.rvalid && vif.rready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %0h expected no response", rdata_pk());
        end else begin
          mon_exp = exp_q.pop_front();
          mon_acc = acc_cyc_q.pop_front();
          chk("rdata", rdata_pk(), mon_exp);
          rsp_count++;
          if (lat_check) chk("latency_cycle", VW'(cyc), VW'(mon_acc));
        end
      end else if (vif.rvalid) begin
        held   = rdata_pk();
        held_v = 1'b1;
      end
    end
  end

  initial begin
    int c0;
    int w;
    logic [AVW-1:0] ra;

    vif.valid  = 1'b0;
    vif.write  = 1'b0;
    vif.rready = 1'b1;
    for (int i = 0; i < P; i++) begin
      vif.addr[i]  = '0;
      vif.wdata[i] = '0;
    end

    // Reset state.
    #1;
    chk("reset_ready", VW'(vif.ready), VW'(0));
    chk("reset_rvalid", VW'(vif.rvalid), VW'(0));
    chk("reset_rdata", rdata_pk(), '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", VW'(vif.ready), VW'(0));
    @(posedge clk);
    #1;
    chk("ready_after_release", VW'(vif.ready), VW'(1));

    lat_check = 1'b1;

    // Basic write then read on the very next edge.
    send(1'b1, pa(0, 1, 2, 3), pk(32'hA, 32'hB, 32'hC, 32'hD), '0, 1'b0);
    send(1'b0, pa(3, 2, 1, 0), '0, pk(32'hD, 32'hC, 32'hB, 32'hA), 1'b0);

    // Lane conflict: highest lane wins, duplicate read lanes agree.
    send(1'b1, pa(5, 5, 5, 5), pk(32'd1, 32'd2, 32'd3, 32'd4), '0, 1'b0);
    send(1'b0, pa(5, 5, 0, 5), '0, pk(32'd4, 32'd4, 32'hA, 32'd4), 1'b0);

    // Out-of-range lanes (LENGTH=12).
    send(1'b1, pa(12, 13, 4, 4), pk(32'd7, 32'd7, 32'd9, 32'd8), '0, 1'b0);
    send(1'b0, pa(12, 4, 13, 4), '0, pk(32'd0, 32'd8, 32'd0, 32'd8), 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: two reads fill the FIFO, the third waits for a pop.
    lat_check  = 1'b0;
    vif.rready = 1'b0;
    send(1'b0, pa(0, 1, 2, 3), '0, pk(32'hA, 32'hB, 32'hC, 32'hD), 1'b0);
    send(1'b0, pa(5, 4, 3, 2), '0, pk(32'd4, 32'd8, 32'hD, 32'hC), 1'b0);
    fork
      send(1'b0, pa(4, 5, 0, 0), '0, pk(32'd8, 32'd4, 32'hA, 32'hA), 1'b0);
      begin
        @(negedge clk);
        chk("bp_ready_low", VW'(vif.ready), VW'(0));
        chk("bp_rvalid", VW'(vif.rvalid), VW'(1));
        repeat (2) @(negedge clk);
        chk("bp_ready_still_low", VW'(vif.ready), VW'(0));
        @(posedge clk);
        #1 vif.rready = 1'b1;
      end
    join
    idle();
    repeat (4) @(posedge clk);
    #1;

    // Reset with two responses queued.
    vif.rready = 1'b0;
    send(1'b0, pa(0, 0, 0, 0), '0, pk(32'hA, 32'hA, 32'hA, 32'hA), 1'b0);
    send(1'b0, pa(1, 1, 1, 1), '0, pk(32'hB, 32'hB, 32'hB, 32'hB), 1'b0);
    idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", VW'(vif.rvalid), VW'(0));
    chk("midrst_ready", VW'(vif.ready), VW'(0));
    chk("midrst_rdata", rdata_pk(), '0);
    exp_q.delete();
    acc_cyc_q.delete();
    vif.valid  = 1'b1;
    vif.write  = 1'b0;
    vif.rready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_pre_edge", VW'(vif.ready), VW'(0));
    @(posedge clk);
    #1;
    chk("midrst_ready_post_edge", VW'(vif.ready), VW'(1));
    chk("midrst_not_accepted", VW'(vif.rvalid), VW'(0));
    idle();
    repeat (4) @(posedge clk);
    #1;

    // Memory survives reset.
    lat_check = 1'b1;
    send(1'b0, pa(3, 2, 1, 0), '0, pk(32'hD, 32'hC, 32'hB, 32'hA), 1'b0);

    // Streaming: fill all entries, then 100 back-to-back random reads.
    for (int b = 0; b < LEN; b += P) begin
      send(1'b1, pa(b, b + 1, b + 2, b + 3),
           pk($urandom, $urandom, $urandom, $urandom), '0, 1'b0);
    end
    c0 = cyc;
    for (int k = 0; k < 100; k++) begin
      ra = pa($urandom_range(0, LEN - 1), $urandom_range(0, LEN - 1),
              $urandom_range(0, LEN - 1), $urandom_range(0, LEN - 1));
      send(1'b0, ra, '0, '0, 1'b1);
    end
    chk("stream_cycles", VW'(cyc - c0), VW'(100));
    idle();

    w = 0;
    while (exp_q.size() > 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    repeat (2) @(posedge clk);
    chk("drain_empty", VW'(exp_q.size()), VW'(0));
    chk("rsp_count", VW'(rsp_count), VW'(107));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
